// File: rtl/bus_mux_arb.sv
// Registered NUM_IN:1 bus multiplexer with direct-select or round-robin channel choice.
// Optional macro BUS_MUX_ARB_PARITY_EN adds a registered even-parity output (out_parity).
module bus_mux_arb #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
`ifdef BUS_MUX_ARB_PARITY_EN
    output logic                    out_parity,
`endif
    input  logic                    out_ready
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             parity_q, parity_d;

    logic             can_load;
    logic             found;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] sel_data;
    logic             xfer;

    assign can_load = ~valid_q | out_ready;

    // Round-robin search starts just past the last granted channel and wraps.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx   = '0;
        if (!mode) begin
            if (32'(sel) < NUM_IN) begin
                found = 1'b1;
                cand  = sel;
            end
        end else begin
            for (int unsigned i = 1; i <= NUM_IN; i++) begin
                idx = SEL_W'((32'(last_q) + i) % NUM_IN);
                if (!found && in_valid[idx]) begin
                    found = 1'b1;
                    cand  = idx;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (found && (32'(cand) == k)) begin
                in_ready[k] = can_load;
                sel_data    = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        src_d    = src_q;
        last_d   = last_q;
        parity_d = parity_q;
        if (xfer) begin
            valid_d  = 1'b1;
            data_d   = sel_data;
            src_d    = cand;
            parity_d = ^sel_data;
            if (mode) begin
                last_d = cand;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            src_q    <= '0;
            last_q   <= SEL_W'(NUM_IN - 1);
            parity_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            src_q    <= src_d;
            last_q   <= last_d;
            parity_q <= parity_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;

`ifdef BUS_MUX_ARB_PARITY_EN
    assign out_parity = parity_q;
`else
    logic unused_parity;
    assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_bus_mux_arb.sv
// Self-checking bench for bus_mux_arb: directed literal checks plus random stimulus
// compared every cycle against a transaction-level model.
module tb_bus_mux_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [3:0]  in_valid = 4'b0;
    logic [63:0] in_data = 64'h0;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_src;
    logic        out_ready = 1'b1;

    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = 2'd0;
    logic [2:0]  in_valid3 = 3'b0;
    logic [47:0] in_data3 = 48'h0;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [15:0] out_data3;
    logic [1:0]  out_src3;
`ifdef BUS_MUX_ARB_PARITY_EN
    logic        out_parity;
    logic        out_parity3;
`endif

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bus_mux_arb #(.WIDTH(16), .NUM_IN(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_src(out_src),
`ifdef BUS_MUX_ARB_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready(out_ready)
    );

    bus_mux_arb #(.WIDTH(16), .NUM_IN(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_valid(in_valid3),
        .in_data(in_data3), .in_ready(in_ready3), .out_valid(out_valid3),
        .out_data(out_data3), .out_src(out_src3),
`ifdef BUS_MUX_ARB_PARITY_EN
        .out_parity(out_parity3),
`endif
        .out_ready(1'b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model of the 4-channel instance.
    bit          m_valid = 1'b0;
    logic [15:0] m_data = 16'h0;
    int          m_src = 0;
    int          m_last = 3;
    bit          n_valid;
    logic [15:0] n_data;
    int          n_src;
    int          n_last;

    always @(negedge clk) begin
        if (chk_en) begin
            bit   found;
            int   cand;
            logic [3:0] exp_ready;
            found = 1'b0;
            cand = 0;
            if (!mode) begin
                found = 1'b1;
                cand = int'(sel);
            end else begin
                for (int i = 1; i <= 4; i++) begin
                    int c;
                    c = (m_last + i) % 4;
                    if (!found && in_valid[c]) begin
                        found = 1'b1;
                        cand = c;
                    end
                end
            end
            exp_ready = (found && (!m_valid || out_ready)) ? 4'(1 << cand) : 4'b0;
            check("model_in_ready", 32'(in_ready), 32'(exp_ready));
            check("model_out_valid", 32'(out_valid), 32'(m_valid));
            check("model_out_data", 32'(out_data), 32'(m_data));
            check("model_out_src", 32'(out_src), 32'(m_src));
`ifdef BUS_MUX_ARB_PARITY_EN
            check("model_out_parity", 32'(out_parity), 32'($countones(m_data) % 2));
`endif
            n_valid = m_valid;
            n_data = m_data;
            n_src = m_src;
            n_last = m_last;
            if (rst) begin
                n_valid = 1'b0;
                n_data = 16'h0;
                n_src = 0;
                n_last = 3;
            end else if ((exp_ready & in_valid) != 4'b0) begin
                n_valid = 1'b1;
                n_data = in_data[cand*16 +: 16];
                n_src = cand;
                if (mode) n_last = cand;
            end else if (m_valid && out_ready) begin
                n_valid = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            m_valid <= n_valid;
            m_data <= n_data;
            m_src <= n_src;
            m_last <= n_last;
        end
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_src", 32'(out_src), 32'd0);
        rst = 1'b0;

        // Direct select of channel 2.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        in_data = {16'h3333, 16'hA5A5, 16'h1111, 16'h0000};
        #1 check("direct_in_ready", 32'(in_ready), 32'h4);
        step();
        check("direct_out_valid", 32'(out_valid), 32'd1);
        check("direct_out_data", 32'(out_data), 32'hA5A5);
        check("direct_out_src", 32'(out_src), 32'd2);
        in_valid = 4'b0;
        step();
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Round-robin over four always-valid channels; direct mode left last at 3.
        in_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_out_src", 32'(out_src), 32'(i % 4));
            check("rr_out_valid", 32'(out_valid), 32'd1);
        end
        check("rr_out_data", 32'(out_data), 32'h0000);

        // Backpressure holding 16'h1111.
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010;
        step();
        check("bp_load_data", 32'(out_data), 32'h1111);
        sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", 32'(in_ready), 32'h0);
            step();
            check("bp_hold_data", 32'(out_data), 32'h1111);
            check("bp_hold_src", 32'(out_src), 32'd1);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(in_ready), 32'h4);
        step();
        check("bp_release_data", 32'(out_data), 32'h2222);
        in_valid = 4'b0;
        step();

        // Round-robin with 4'b1010 after a grant to channel 3.
        mode = 1'b1; in_valid = 4'b1000;
        step();
        check("rr2_first_src", 32'(out_src), 32'd3);
        in_valid = 4'b1010;
        step();
        check("rr2_src_a", 32'(out_src), 32'd1);
        step();
        check("rr2_src_b", 32'(out_src), 32'd3);
        step();
        check("rr2_src_c", 32'(out_src), 32'd1);
        in_valid = 4'b0;
        step();

        // Out-of-range select on the 3-channel instance.
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        in_data3 = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        #1 check("n3_in_ready_oob", 32'(in_ready3), 32'h0);
        step();
        step();
        check("n3_out_valid_oob", 32'(out_valid3), 32'd0);
        sel3 = 2'd1;
        #1 check("n3_in_ready_sel1", 32'(in_ready3), 32'h2);
        step();
        check("n3_out_data", 32'(out_data3), 32'hBBBB);
        check("n3_out_src", 32'(out_src3), 32'd1);
        in_valid3 = 3'b0;

        // Reset wins over a pending transfer; round-robin restarts at channel 0.
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {16'h3333, 16'h2222, 16'h1111, 16'h0007};
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_src", 32'(out_src), 32'd0);
        check("post_rst_data", 32'(out_data), 32'h0007);
`ifdef BUS_MUX_ARB_PARITY_EN
        check("post_rst_parity", 32'(out_parity), 32'd1);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            mode = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            in_valid = 4'($urandom_range(0, 15));
            in_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
